// File: rtl/signal_unswitch.sv
// Receiving end of the channel-swap path: delays the swap control to match the
// processing latency, restores a/b from x/y and blanks valid after each swap.
module signal_unswitch #(
    parameter int DATA_WIDTH    = 16,
    parameter int DELAY_WIDTH   = 5,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   switch,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [DATA_WIDTH-1:0]  x_in,
    input  logic [DATA_WIDTH-1:0]  y_in,
    input  logic                   valid_in,
    output logic [DATA_WIDTH-1:0]  a_out,
    output logic [DATA_WIDTH-1:0]  b_out,
    output logic                   valid_out,
    output logic                   busy,
    output logic [15:0]            swap_count
);

    localparam int DEPTH    = 2 ** DELAY_WIDTH;
    localparam int CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam bit BLANK_EN = (SETTLE_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    localparam logic [0:0] PASS  = 1'b0;
    localparam logic [0:0] BLANK = 1'b1;

    logic [DEPTH-1:0]      hist_reg;
    logic                  sw_d;
    logic                  sw_q_reg;
    logic                  swap_edge;

    logic [0:0]            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  valid_next;
    logic                  busy_next;

    logic [DATA_WIDTH-1:0] a_next;
    logic [DATA_WIDTH-1:0] b_next;

    // Switch history; tap 0 already carries one cycle of delay.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hist_reg <= '0;
            sw_q_reg <= 1'b0;
        end else begin
            hist_reg <= {hist_reg[DEPTH-2:0], switch};
            sw_q_reg <= sw_d;
        end
    end

    assign sw_d      = hist_reg[delay];
    assign swap_edge = (sw_d != sw_q_reg);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_swap
            assign a_next[gi] = sw_d ? y_in[gi] : x_in[gi];
            assign b_next[gi] = sw_d ? x_in[gi] : y_in[gi];
        end
    endgenerate

    // Any edge inside BLANK restarts the settle window from the top.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_in;
        busy_next  = 1'b0;
        case (state_reg)
            PASS: begin
                if (swap_edge && BLANK_EN) begin
                    state_next = BLANK;
                    cnt_next   = CNT_LOAD;
                    valid_next = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            BLANK: begin
                if (swap_edge) begin
                    cnt_next   = CNT_LOAD;
                    valid_next = 1'b0;
                    busy_next  = 1'b1;
                end else if (cnt_reg != '0) begin
                    cnt_next   = cnt_reg - 1'b1;
                    valid_next = 1'b0;
                    busy_next  = 1'b1;
                end else begin
                    state_next = PASS;
                end
            end
            default: begin
                state_next = PASS;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg  <= PASS;
            cnt_reg    <= '0;
            a_out      <= '0;
            b_out      <= '0;
            valid_out  <= 1'b0;
            busy       <= 1'b0;
            swap_count <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_out     <= a_next;
            b_out     <= b_next;
            valid_out <= valid_next;
            busy      <= busy_next;
            if (swap_edge) begin
                swap_count <= swap_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_signal_unswitch.sv
// Directed bench for signal_unswitch: reset, pass-through, delayed swap with
// settle blanking, window restart, reset mid-blank and delay retune.
module tb_signal_unswitch;

    logic        aclk;
    logic        areset;
    logic        switch;
    logic [4:0]  delay;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic        valid_in;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic        valid_out;
    logic        busy;
    logic [15:0] swap_count;

    int checks = 0;
    int errors = 0;

    signal_unswitch #(
        .DATA_WIDTH   (16),
        .DELAY_WIDTH  (5),
        .SETTLE_CYCLES(4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .switch    (switch),
        .delay     (delay),
        .x_in      (x_in),
        .y_in      (y_in),
        .valid_in  (valid_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .valid_out (valid_out),
        .busy      (busy),
        .swap_count(swap_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                             input logic ev, input logic eb_busy, input logic [15:0] ec);
        check({tag, ".a"}, a_out, ea);
        check({tag, ".b"}, b_out, eb);
        check({tag, ".valid"}, valid_out, ev);
        check({tag, ".busy"}, busy, eb_busy);
        check({tag, ".count"}, swap_count, ec);
    endtask

    initial begin
        logic        exp_sw;
        logic        exp_blank;
        logic [15:0] exp_cnt;
        logic        v;

        // 1: reset with random inputs
        areset   = 1'b1;
        switch   = 1'b0;
        delay    = '0;
        x_in     = '0;
        y_in     = '0;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            switch   = 1'($urandom);
            delay    = 5'($urandom);
            x_in     = 16'($urandom);
            y_in     = 16'($urandom);
            valid_in = 1'($urandom);
            tick();
            check_all($sformatf("rst%0d", i), 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        end
        switch   = 1'b0;
        delay    = 5'd0;
        x_in     = 16'h1234;
        y_in     = 16'hABCD;
        valid_in = 1'b1;
        areset   = 1'b0;
        #1;
        check_all("release", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);

        // 2: straight pass-through
        tick();
        check_all("pass", 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h0);

        // 3: delay=3, switch 0->1; output mapping flips on the 5th edge
        delay  = 5'd3;
        switch = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_sw    = (i >= 5);
            exp_blank = (i >= 5) && (i <= 8);
            check_all($sformatf("dly3_%0d", i),
                      exp_sw ? 16'hABCD : 16'h1234, exp_sw ? 16'h1234 : 16'hABCD,
                      !exp_blank, exp_blank, exp_sw ? 16'd1 : 16'd0);
        end

        // return to switch=0 and let the window expire
        switch = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_all("back0", 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'd2);

        // 4: two-cycle pulse at delay 0; second edge restarts the window
        delay  = 5'd0;
        switch = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) switch = 1'b0;
            tick();
            exp_sw    = (i == 2) || (i == 3);
            exp_blank = (i >= 2) && (i <= 7);
            exp_cnt   = (i < 2) ? 16'd2 : ((i < 4) ? 16'd3 : 16'd4);
            check_all($sformatf("pulse_%0d", i),
                      exp_sw ? 16'hABCD : 16'h1234, exp_sw ? 16'h1234 : 16'hABCD,
                      !exp_blank, exp_blank, exp_cnt);
        end

        // 5: asynchronous reset in the middle of a blank window
        switch = 1'b1;
        tick();
        tick();
        check("mid.busy", busy, 1'b1);
        check("mid.count", swap_count, 16'd5);
        tick();
        areset = 1'b1;
        #1;
        check_all("async", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        switch = 1'b0;
        tick();
        check_all("hold", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        areset = 1'b0;
        tick();
        check_all("post1", 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h0);
        tick();
        check_all("post2", 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h0);

        // 6: switch held high past history depth, then retune delay 3->0
        delay  = 5'd3;
        switch = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check_all("held", 16'hABCD, 16'h1234, 1'b1, 1'b0, 16'd1);
        delay = 5'd0;
        for (int i = 0; i < 6; i++) begin
            v        = (i % 2) == 1;
            x_in     = 16'h1000 + 16'(i);
            y_in     = 16'h2000 + 16'(i);
            valid_in = v;
            tick();
            check_all($sformatf("retune_%0d", i), 16'h2000 + 16'(i), 16'h1000 + 16'(i),
                      v, 1'b0, 16'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
